// File: rtl/corelet_pkg.sv
// Shared constants and state encoding for the corelet SRAM loader and corelet FSM.
package corelet_pkg;

    localparam int BW        = 4;
    localparam int ROW       = 8;
    localparam int KIJ_NUM   = 9;
    localparam int ACT_WORDS = 36;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = BW * ROW;
    localparam int W_WORDS   = ROW * KIJ_NUM;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_W    = 3'd1,
        ST_LOAD_ACT  = 3'd2,
        ST_KICK      = 3'd3,
        ST_WAIT_CORE = 3'd4
    } loader_state_t;

endpackage

// File: rtl/sram_wr_port.sv
// Registered write-side driver for one single-port SRAM (active-low strobes).
module sram_wr_port
    import corelet_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DATA_W = DATA_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [P_ADDR_W-1:0] i_addr,
    input  logic [P_DATA_W-1:0] i_data,
    output logic                o_cen,
    output logic                o_wen,
    output logic [P_ADDR_W-1:0] o_addr,
    output logic [P_DATA_W-1:0] o_d
);

    // A write request becomes one strobe cycle; address and data hold between writes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cen  <= 1'b1;
            o_wen  <= 1'b1;
            o_addr <= '0;
            o_d    <= '0;
        end else if (i_wr) begin
            o_cen  <= 1'b0;
            o_wen  <= 1'b0;
            o_addr <= i_addr;
            o_d    <= i_data;
        end else begin
            o_cen  <= 1'b1;
            o_wen  <= 1'b1;
        end
    end

endmodule

// File: rtl/aw_sram_loader.sv
// Loads weights then activations from a host stream into the corelet SRAMs,
// then kicks the corelet and reports completion.
module aw_sram_loader
    import corelet_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_skip_w,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_w_d,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_w_cen,
    output logic              o_w_wen,
    output logic [DATA_W-1:0] o_act_d,
    output logic [ADDR_W-1:0] o_act_addr,
    output logic              o_act_cen,
    output logic              o_act_wen,
    output logic              o_seq_begin,
    input  logic              i_seq_done,
    output logic              o_busy,
    output logic              o_done
);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_wCnt;
    logic [ADDR_W-1:0] r_aCnt;
    logic              r_seqBegin;
    logic              r_busy;
    logic              r_done;

    logic w_inReady;
    logic w_hs;
    logic w_wWr;
    logic w_actWr;

    // Ready comes only from the registered state, so in_valid never loops back to in_ready.
    assign w_inReady = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_ACT);
    assign w_hs      = i_in_valid && w_inReady;
    assign w_wWr     = w_hs && (r_state == ST_LOAD_W);
    assign w_actWr   = w_hs && (r_state == ST_LOAD_ACT);

    assign o_in_ready  = w_inReady;
    assign o_seq_begin = r_seqBegin;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    // Sequencer: the last handshake of each phase moves state on the same edge, so counters never wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_wCnt     <= '0;
            r_aCnt     <= '0;
            r_seqBegin <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_seqBegin <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_wCnt  <= '0;
                        r_aCnt  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= i_skip_w ? ST_LOAD_ACT : ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (w_hs) begin
                        r_wCnt <= r_wCnt + ADDR_W'(1);
                        if (r_wCnt == ADDR_W'(W_WORDS - 1)) begin
                            r_state <= ST_LOAD_ACT;
                        end
                    end
                end
                ST_LOAD_ACT: begin
                    if (w_hs) begin
                        r_aCnt <= r_aCnt + ADDR_W'(1);
                        if (r_aCnt == ADDR_W'(ACT_WORDS - 1)) begin
                            r_state <= ST_KICK;
                        end
                    end
                end
                ST_KICK: begin
                    r_seqBegin <= 1'b1;
                    r_state    <= ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    if (i_seq_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sram_wr_port u_wPort (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (w_wWr),
        .i_addr  (r_wCnt),
        .i_data  (i_in_data),
        .o_cen   (o_w_cen),
        .o_wen   (o_w_wen),
        .o_addr  (o_w_addr),
        .o_d     (o_w_d)
    );

    sram_wr_port u_actPort (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (w_actWr),
        .i_addr  (r_aCnt),
        .i_data  (i_in_data),
        .o_cen   (o_act_cen),
        .o_wen   (o_act_wen),
        .o_addr  (o_act_addr),
        .o_d     (o_act_d)
    );

endmodule

// File: tb/tb_aw_sram_loader.sv
// Directed self-checking bench for aw_sram_loader with an SRAM write monitor.
module tb_aw_sram_loader;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_skip_w;
    logic [31:0] i_in_data;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] o_w_d;
    logic [6:0]  o_w_addr;
    logic        o_w_cen;
    logic        o_w_wen;
    logic [31:0] o_act_d;
    logic [6:0]  o_act_addr;
    logic        o_act_cen;
    logic        o_act_wen;
    logic        o_seq_begin;
    logic        i_seq_done;
    logic        o_busy;
    logic        o_done;

    int totalChecks = 0;
    int badChecks   = 0;

    int          cyc = 0;
    logic [31:0] wMem [128];
    logic [31:0] aMem [128];
    bit          wSeen [128];
    bit          aSeen [128];
    int wWrites, aWrites, wDup, aDup, bothLow, wenBad;
    int seqCnt, seqCyc, lastActCyc, doneCnt, doneBusyBad;

    aw_sram_loader dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_skip_w    (i_skip_w),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_w_d       (o_w_d),
        .o_w_addr    (o_w_addr),
        .o_w_cen     (o_w_cen),
        .o_w_wen     (o_w_wen),
        .o_act_d     (o_act_d),
        .o_act_addr  (o_act_addr),
        .o_act_cen   (o_act_cen),
        .o_act_wen   (o_act_wen),
        .o_seq_begin (o_seq_begin),
        .i_seq_done  (i_seq_done),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to relate write strobes to the seq_begin pulse.
    always @(posedge clk) cyc++;

    // Mid-cycle monitor that models both SRAMs and records strobe statistics.
    always @(negedge clk) begin
        if (o_w_cen === 1'b0) begin
            wWrites++;
            if (o_w_wen !== 1'b0) wenBad++;
            if (wSeen[o_w_addr]) wDup++;
            wSeen[o_w_addr] = 1'b1;
            wMem[o_w_addr]  = o_w_d;
        end
        if (o_act_cen === 1'b0) begin
            aWrites++;
            if (o_act_wen !== 1'b0) wenBad++;
            if (aSeen[o_act_addr]) aDup++;
            aSeen[o_act_addr] = 1'b1;
            aMem[o_act_addr]  = o_act_d;
            lastActCyc = cyc;
        end
        if (o_w_cen === 1'b0 && o_act_cen === 1'b0) bothLow++;
        if (o_seq_begin === 1'b1) begin
            seqCnt++;
            seqCyc = cyc;
        end
        if (o_done === 1'b1) begin
            doneCnt++;
            if (o_busy !== 1'b0) doneBusyBad++;
        end
    end

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Clears the monitor; called just after a rising edge so it never races the monitor.
    task automatic clearStats();
        @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) begin
            wSeen[i] = 1'b0;
            aSeen[i] = 1'b0;
            wMem[i]  = 32'hDEAD_BEEF;
            aMem[i]  = 32'hDEAD_BEEF;
        end
        wWrites = 0; aWrites = 0; wDup = 0; aDup = 0; bothLow = 0; wenBad = 0;
        seqCnt = 0; seqCyc = -100; lastActCyc = -200; doneCnt = 0; doneBusyBad = 0;
    endtask

    // One-cycle start pulse with the given skip_w.
    task automatic pulseStart(input bit skip);
        @(negedge clk);
        i_start  = 1'b1;
        i_skip_w = skip;
        @(negedge clk);
        i_start  = 1'b0;
        i_skip_w = 1'b0;
    endtask

    // Streams n words base+k; optional gap after each handshake and stray start/seq_done pulses.
    task automatic applyStimulus(input logic [31:0] base, input int n, input bit gap,
                                 input int startAt, input int doneAt);
        int k = 0;
        int stall = 0;
        while (k < n) begin
            @(negedge clk);
            i_in_valid = 1'b1;
            i_in_data  = base + k;
            i_start    = (k == startAt);
            i_seq_done = (k == doneAt);
            if (o_in_ready === 1'b1) begin
                k++;
                stall = 0;
                if (gap && k < n) begin
                    @(negedge clk);
                    i_in_valid = 1'b0;
                    i_start    = 1'b0;
                    i_seq_done = 1'b0;
                end
            end else begin
                stall++;
                if (stall > 50) begin
                    checkOutput("readyTimeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        @(negedge clk);
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        i_seq_done = 1'b0;
    endtask

    // Waits for seq_begin, answers with seq_done and checks the completion pulse.
    task automatic finishSeq();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_seq_begin === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("seqBeginSeen", 32'(found), 32'd1);
        if (found) begin
            checkOutput("busyAtKick", 32'(o_busy), 32'd1);
            checkOutput("doneBeforeCore", 32'(o_done), 32'd0);
            @(negedge clk);
            i_seq_done = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("doneHigh", 32'(o_done), 32'd1);
            checkOutput("busyLowAtDone", 32'(o_busy), 32'd0);
            i_seq_done = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("doneOneCycle", 32'(o_done), 32'd0);
        end
    endtask

    // Compares the modelled SRAM contents against the words that were streamed.
    task automatic checkContents(input logic [31:0] wBase, input int nW, input logic [31:0] aBase, input int nA);
        int wErr = 0;
        int aErr = 0;
        for (int k = 0; k < nW; k++) if (wMem[k] !== wBase + k) wErr++;
        for (int j = 0; j < nA; j++) if (aMem[j] !== aBase + j) aErr++;
        checkOutput("wContent", wErr, 0);
        checkOutput("actContent", aErr, 0);
    endtask

    // Write counts, duplicates, port exclusivity and pulse timing for one full sequence.
    task automatic checkStats(input int expW, input int expA);
        checkOutput("wWrites", wWrites, expW);
        checkOutput("actWrites", aWrites, expA);
        checkOutput("wDup", wDup, 0);
        checkOutput("actDup", aDup, 0);
        checkOutput("bothCenLow", bothLow, 0);
        checkOutput("wenWithCen", wenBad, 0);
        checkOutput("seqBeginCount", seqCnt, 1);
        checkOutput("seqBeginDelay", seqCyc - lastActCyc, 1);
        checkOutput("doneCount", doneCnt, 1);
        checkOutput("doneBusy", doneBusyBad, 0);
    endtask

    // Directed scenarios.
    initial begin
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_skip_w   = 1'b0;
        i_in_data  = 32'h0;
        i_in_valid = 1'b1;
        i_seq_done = 1'b0;
        clearStats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWCen", 32'(o_w_cen), 32'd1);
        checkOutput("rstWWen", 32'(o_w_wen), 32'd1);
        checkOutput("rstWAddr", 32'(o_w_addr), 32'd0);
        checkOutput("rstWD", o_w_d, 32'd0);
        checkOutput("rstActCen", 32'(o_act_cen), 32'd1);
        checkOutput("rstActWen", 32'(o_act_wen), 32'd1);
        checkOutput("rstActAddr", 32'(o_act_addr), 32'd0);
        checkOutput("rstActD", o_act_d, 32'd0);
        checkOutput("rstReady", 32'(o_in_ready), 32'd0);
        checkOutput("rstSeqBegin", 32'(o_seq_begin), 32'd0);
        checkOutput("rstBusy", 32'(o_busy), 32'd0);
        checkOutput("rstDone", 32'(o_done), 32'd0);
        i_reset    = 1'b0;
        i_in_valid = 1'b0;

        $display("[TB] scenario 1: full load");
        clearStats();
        pulseStart(1'b0);
        checkOutput("t1Busy", 32'(o_busy), 32'd1);
        checkOutput("t1Ready", 32'(o_in_ready), 32'd1);
        applyStimulus(32'h0000_0100, 72, 1'b0, -1, -1);
        applyStimulus(32'h0000_0200, 36, 1'b0, -1, -1);
        finishSeq();
        checkStats(72, 36);
        checkContents(32'h0000_0100, 72, 32'h0000_0200, 36);
        checkOutput("t1ReadyIdle", 32'(o_in_ready), 32'd0);

        $display("[TB] scenario 2: valid every other cycle");
        clearStats();
        pulseStart(1'b0);
        applyStimulus(32'h0000_0300, 72, 1'b1, -1, -1);
        applyStimulus(32'h0000_0400, 36, 1'b1, -1, -1);
        finishSeq();
        checkStats(72, 36);
        checkContents(32'h0000_0300, 72, 32'h0000_0400, 36);

        $display("[TB] scenario 3: skip weights");
        clearStats();
        i_in_valid = 1'b1;
        i_in_data  = 32'h0000_0EEE;
        repeat (3) @(negedge clk);
        checkOutput("idleValidIgnored", wWrites + aWrites, 0);
        i_in_valid = 1'b0;
        pulseStart(1'b1);
        checkOutput("t3Busy", 32'(o_busy), 32'd1);
        applyStimulus(32'h0000_0500, 36, 1'b0, -1, -1);
        finishSeq();
        checkStats(0, 36);
        checkContents(32'h0, 0, 32'h0000_0500, 36);

        $display("[TB] scenario 4: stray start and seq_done");
        clearStats();
        pulseStart(1'b0);
        applyStimulus(32'h0000_0600, 72, 1'b0, 20, -1);
        applyStimulus(32'h0000_0700, 36, 1'b0, -1, 10);
        checkOutput("t4NoEarlyDone", doneCnt, 0);
        finishSeq();
        checkStats(72, 36);
        checkContents(32'h0000_0600, 72, 32'h0000_0700, 36);

        $display("[TB] scenario 5: reset mid-load");
        clearStats();
        pulseStart(1'b0);
        applyStimulus(32'h0000_0800, 10, 1'b0, -1, -1);
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = 32'h0000_08FF;
        i_reset    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5WCen", 32'(o_w_cen), 32'd1);
        checkOutput("t5Ready", 32'(o_in_ready), 32'd0);
        checkOutput("t5Busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        i_reset    = 1'b0;
        i_in_valid = 1'b0;
        checkOutput("t5WritesBeforeReset", wWrites, 10);
        clearStats();
        pulseStart(1'b0);
        applyStimulus(32'h0000_0900, 72, 1'b0, -1, -1);
        applyStimulus(32'h0000_0A00, 36, 1'b0, -1, -1);
        finishSeq();
        checkStats(72, 36);
        checkContents(32'h0000_0900, 72, 32'h0000_0A00, 36);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
